// File: rtl/cpu_fetch.sv
// ---------------------------------------------------------------------------
// cpu_fetch -- instruction fetch unit with a small in-order instruction buffer
//
// Issues at most one instruction-memory request at a time, tags each request
// with its address, and queues returned words in a BUF_DEPTH-entry circular
// buffer that feeds decode. A redirect flushes the buffer and cancels or
// drains whatever request is in flight. The pc_next output feeds the external
// PC register.
//
// Parameters:
//   PC_INC     byte increment between sequential instructions (default 4)
//   BUF_DEPTH  instruction buffer entries, 2 or 4 (default 2)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pc / pc_next            current PC in, next PC out
//   imem_req/addr/gnt       request handshake (addr == pc while req == 1)
//   imem_rvalid/rdata       read response, one or more cycles after grant
//   redirect/redirect_pc    taken branch/jump pulse and its target
//   dec_ready               decode accepts the head instruction
//   inst_valid/inst/inst_pc buffer head
//   perf_fetched/bubbles    saturating performance counters, only present
//                           when the macro CPU_FETCH_PERF_EN is defined
// ---------------------------------------------------------------------------
module cpu_fetch #(
    parameter logic [15:0] PC_INC    = 16'd4,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic [15:0] pc_next,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        dec_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [15:0] inst_pc
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_bubbles
`endif
);

    localparam int PTR_W = (BUF_DEPTH == 4) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state;
    logic [15:0]      tag;
    logic [31:0]      buf_data [BUF_DEPTH];
    logic [15:0]      buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic grant;
    logic push;
    logic pop;

    assign imem_req   = (state == REQ);
    assign imem_addr  = imem_req ? pc : 16'h0000;
    assign grant      = imem_req && imem_gnt;
    assign inst_valid = (count != '0);

    // A redirect kills both the incoming word and any pop in the same cycle.
    assign push = (state == WAIT) && imem_rvalid && !redirect;
    assign pop  = inst_valid && dec_ready && !redirect;

    // Head is forced to zero when empty so the outputs read 0 out of reset
    // without having to reset the storage array.
    assign inst    = inst_valid ? buf_data[rd_ptr] : 32'h0;
    assign inst_pc = inst_valid ? buf_pc[rd_ptr]   : 16'h0;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (!push && pop)
            count_nxt = count - CNT_W'(1);
    end

    // pc_next is forced to 0 while reset is held, independent of the PC input.
    always_comb begin
        pc_next = pc;
        if (!rst_n)
            pc_next = 16'h0000;
        else if (redirect)
            pc_next = redirect_pc;
        else if (grant)
            pc_next = pc + PC_INC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tag    <= 16'h0000;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            case (state)
                // A redirect from IDLE goes straight to REQ so the target is
                // requested on the very next cycle.
                IDLE: if (redirect || (count < DEPTH_C)) state <= REQ;
                REQ: begin
                    if (grant) begin
                        tag   <= pc;
                        state <= redirect ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect || (count_nxt < DEPTH_C))
                            state <= REQ;
                        else
                            state <= IDLE;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                // Stay here until the abandoned response returns; a redirect
                // only retargets the PC. A response in the same cycle as a
                // redirect still retires the outstanding request.
                DROP: if (imem_rvalid) state <= REQ;
                default: state <= IDLE;
            endcase

            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_nxt;
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= tag;
        end
    end

`ifdef CPU_FETCH_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 16'h0000;
            perf_bubbles <= 16'h0000;
        end else begin
            if (push)
                perf_fetched <= sat_inc(perf_fetched);
            if (!inst_valid && dec_ready)
                perf_bubbles <= sat_inc(perf_bubbles);
        end
    end
`endif

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter PC_INC, default 16'd4, byte increment between sequential instructions.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries; legal values are 2 and 4 only.
REQ-003 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pc  input  16  current PC from the PC register.
REQ-006 SHALL have port pc_next  output  16  next PC value fed back to the PC register.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-008 SHALL have port imem_addr  output  16  request address, equal to pc while imem_req=1.
REQ-009 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 SHALL have port imem_rvalid  input  1  read data valid, latency 1 or more cycles after the grant.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port redirect  input  1  branch/jump taken, one-cycle pulse.
REQ-013 SHALL have port redirect_pc  input  16  redirect target.
REQ-014 SHALL have port dec_ready  input  1  decode accepts inst this cycle.
REQ-015 SHALL have port inst_valid  output  1  buffer head valid.
REQ-016 SHALL have port inst  output  32  buffer head instruction.
REQ-017 SHALL have port inst_pc  output  16  address of the buffer-head instruction.

Function
REQ-018 SHALL use FSM states IDLE, REQ, WAIT and DROP, with at most one outstanding memory request.
REQ-019 IDLE SHALL move to REQ when free buffer slots are 1 or more; a slot counts as free if it is empty and not reserved by an outstanding request.
REQ-020 REQ SHALL assert imem_req; on imem_gnt it SHALL move to WAIT, latch the request address as tag, and set pc_next=pc+PC_INC (mod 2^16, wrap 16'hFFFC+4=16'h0000).
REQ-021 When there is no grant and no redirect, pc_next SHALL equal pc (the PC holds).
REQ-022 WAIT SHALL, on imem_rvalid, push {imem_rdata, tag} into the buffer, then go to REQ if a slot is free, else to IDLE.
REQ-023 A push and a pop in the same cycle SHALL both occur; occupancy is unchanged.
REQ-024 Pop SHALL occur when inst_valid && dec_ready; inst and inst_pc SHALL be held stable while inst_valid && !dec_ready.
REQ-025 On redirect, pc_next SHALL equal redirect_pc, the buffer SHALL be flushed (inst_valid=0 the next cycle), and any pop that cycle SHALL be ignored.
REQ-026 On redirect in REQ with imem_gnt in the same cycle, the granted response SHALL be discarded: go to DROP.
REQ-027 On redirect in REQ without a grant, the block SHALL drop the request and go to REQ, issuing the new address the next cycle.
REQ-028 On redirect in WAIT without imem_rvalid, the block SHALL go to DROP; with imem_rvalid in the same cycle, the data SHALL be discarded and the block SHALL go to REQ.
REQ-029 DROP SHALL keep imem_req=0, discard the next imem_rvalid, and then go to REQ.
REQ-030 A redirect while already in DROP SHALL update pc_next only, and the block SHALL remain in DROP.
REQ-031 imem_rvalid in IDLE or REQ is a protocol error and SHALL be ignored.
REQ-032 Latency SHALL be: grant with 1-cycle memory gives inst_valid 2 cycles after imem_req first asserts; a redirect gives its first request 1 cycle later.

Reset
REQ-033 On rst_n low, the FSM SHALL be IDLE, the buffer empty, and the tag 0; outputs SHALL be imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, and pc_next=0.
REQ-034 Reset mid-request SHALL abandon the transaction; any imem_rvalid in the first cycle after release SHALL be ignored.
REQ-035 The first request after reset SHALL be issued on the second posedge after rst_n rises.

Configuration
REQ-036 The macro CPU_FETCH_PERF_EN SHALL control the performance counters.
REQ-037 With CPU_FETCH_PERF_EN defined, the block SHALL add outputs perf_fetched[15:0] (counts pushes) and perf_bubbles[15:0] (counts cycles with inst_valid=0 && dec_ready=1).
REQ-038 The counters SHALL saturate at 16'hFFFF and SHALL be cleared by reset.
REQ-039 Without CPU_FETCH_PERF_EN, the ports and logic SHALL be absent and function SHALL be otherwise identical.

Verification
REQ-040 The bench SHALL cover: reset, pc=0, always grant, 1-cycle rvalid, dec_ready=1 -> inst_pc sequence 0,4,8,... with one instruction per cycle after fill.
REQ-041 The bench SHALL cover: dec_ready=0 for 10 cycles -> BUF_DEPTH entries buffered, imem_req=0, inst constant; on release the entries drain in order with no loss.
REQ-042 The bench SHALL cover: redirect to 16'h0100 while in WAIT -> DROP state, the stale response discarded, next inst_pc=16'h0100.
REQ-043 The bench SHALL cover: redirect coincident with imem_gnt -> the granted word is never presented, pc_next=redirect_pc.
REQ-044 The bench SHALL cover: pc=16'hFFFC granted -> pc_next=16'h0000.
REQ-045 The bench SHALL cover: rst_n asserted during WAIT -> all outputs 0, and a late imem_rvalid produces no inst_valid.
